// File: rtl/shift_sequencer.sv
// Pixel shift sequencer: pops FIFO words into the pixel shifter and issues
// per-depth shift strobes, blanking and end-of-line for one display line.
module shift_sequencer (
  input  logic        dotclk_i,
  input  logic        reset_i,
  input  logic        den_i,
  input  logic [1:0]  mode_i,
  input  logic [10:0] line_len_i,
  input  logic        word_valid_i,
  input  logic [15:0] word_dat_i,
  output logic        word_ack_o,
  output logic [15:0] dat_o,
  output logic        load_o,
  output logic        shift1_o,
  output logic        shift2_o,
  output logic        shift4_o,
  output logic        shift8_o,
  output logic        blank_o,
  output logic        eol_o,
  output logic        underrun_o,
  input  logic        clr_underrun_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [10:0] len_q, len_d;
  logic [10:0] pix_cnt_q, pix_cnt_d;
  logic [3:0]  slot_cnt_q, slot_cnt_d;
  logic        underrun_q, underrun_d;

  logic        underrun_set;
  logic        last_slot;
  logic [3:0]  slots_m1;
  logic [3:0]  shift_vec;
  logic        load, ack, blank, eol;

  // len_q of 0 wraps to 2047 here, giving a 2048-slot line.
  assign last_slot = (pix_cnt_q == (len_q - 11'd1));

  always_comb begin
    slots_m1 = 4'd15;
    case (mode_q)
      2'b00:   slots_m1 = 4'd15;
      2'b01:   slots_m1 = 4'd7;
      2'b10:   slots_m1 = 4'd3;
      default: slots_m1 = 4'd1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    len_d        = len_q;
    pix_cnt_d    = pix_cnt_q;
    slot_cnt_d   = slot_cnt_q;
    underrun_set = 1'b0;
    load         = 1'b0;
    ack          = 1'b0;
    shift_vec    = '0;
    blank        = 1'b1;
    eol          = 1'b0;

    case (state_q)
      IDLE: begin
        if (den_i) begin
          mode_d    = mode_i;
          len_d     = line_len_i;
          pix_cnt_d = '0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (!den_i) begin
          state_d = IDLE;
        end else begin
          pix_cnt_d = pix_cnt_q + 11'd1;
          if (word_valid_i) begin
            load       = 1'b1;
            ack        = 1'b1;
            blank      = 1'b0;
            slot_cnt_d = slots_m1;
            state_d    = SHIFT;
          end else begin
            underrun_set = 1'b1;
          end
          if (last_slot) begin
            eol     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      SHIFT: begin
        if (!den_i) begin
          state_d = IDLE;
        end else begin
          pix_cnt_d  = pix_cnt_q + 11'd1;
          blank      = 1'b0;
          shift_vec  = 4'b0001 << mode_q;
          slot_cnt_d = slot_cnt_q - 4'd1;
          state_d    = (slot_cnt_q == 4'd1) ? FETCH : SHIFT;
          if (last_slot) begin
            eol     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A set in the same cycle as a clear wins.
    underrun_d = underrun_set | (underrun_q & ~clr_underrun_i);
  end

  always_ff @(posedge dotclk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      mode_q     <= 2'b00;
      len_q      <= '0;
      pix_cnt_q  <= '0;
      slot_cnt_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      pix_cnt_q  <= pix_cnt_d;
      slot_cnt_q <= slot_cnt_d;
      underrun_q <= underrun_d;
    end
  end

  // Reset masks every strobe combinationally so nothing leaks in the reset cycle.
  assign dat_o      = word_dat_i;
  assign load_o     = load & ~reset_i;
  assign word_ack_o = ack & ~reset_i;
  assign shift1_o   = shift_vec[0] & ~reset_i;
  assign shift2_o   = shift_vec[1] & ~reset_i;
  assign shift4_o   = shift_vec[2] & ~reset_i;
  assign shift8_o   = shift_vec[3] & ~reset_i;
  assign blank_o    = blank | reset_i;
  assign eol_o      = eol & ~reset_i;
  assign underrun_o = underrun_q & ~reset_i;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: line timing per depth, underrun,
// display-enable drop, mid-line reset and the 2048-slot line.
module tb_shift_sequencer;

  logic        dotclk_i = 1'b0;
  logic        reset_i, den_i, word_valid_i, clr_underrun_i;
  logic [1:0]  mode_i;
  logic [10:0] line_len_i;
  logic [15:0] word_dat_i, dat_o;
  logic        word_ack_o, load_o, shift1_o, shift2_o, shift4_o, shift8_o;
  logic        blank_o, eol_o, underrun_o;
  logic [7:0]  obs_v;

  int tests = 0;
  int fails = 0;

  localparam logic [7:0] V_IDLE  = 8'b00_0000_10;
  localparam logic [7:0] V_LOAD  = 8'b11_0000_00;
  localparam logic [7:0] V_SH1   = 8'b00_0001_00;
  localparam logic [7:0] V_SH2   = 8'b00_0010_00;
  localparam logic [7:0] V_SH4   = 8'b00_0100_00;

  shift_sequencer dut (
    .dotclk_i       (dotclk_i),
    .reset_i        (reset_i),
    .den_i          (den_i),
    .mode_i         (mode_i),
    .line_len_i     (line_len_i),
    .word_valid_i   (word_valid_i),
    .word_dat_i     (word_dat_i),
    .word_ack_o     (word_ack_o),
    .dat_o          (dat_o),
    .load_o         (load_o),
    .shift1_o       (shift1_o),
    .shift2_o       (shift2_o),
    .shift4_o       (shift4_o),
    .shift8_o       (shift8_o),
    .blank_o        (blank_o),
    .eol_o          (eol_o),
    .underrun_o     (underrun_o),
    .clr_underrun_i (clr_underrun_i)
  );

  always #5 dotclk_i = ~dotclk_i;

  assign obs_v = {load_o, word_ack_o, shift8_o, shift4_o, shift2_o, shift1_o, blank_o, eol_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic rst, input logic den, input logic vld,
                       input logic clr, input logic [15:0] dat);
    reset_i        = rst;
    den_i          = den;
    word_valid_i   = vld;
    clr_underrun_i = clr;
    word_dat_i     = dat;
    #1;
  endtask

  task automatic adv();
    @(negedge dotclk_i);
  endtask

  // Full line with the FIFO always valid; mode/len inputs are scrambled mid-line.
  task automatic run_full(input logic [1:0] m, input logic [10:0] len, input int nslots,
                          input int exp_loads, input int exp_shifts, input string tag);
    int n;
    int loads, acks, shifts, eols;
    logic [15:0] w;
    logic [7:0]  exp;
    n = 16 >> m;
    loads = 0; acks = 0; shifts = 0; eols = 0;
    mode_i = m;
    line_len_i = len;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    chk({tag, "_idle"}, obs_v, V_IDLE);
    adv();
    for (int s = 0; s < nslots; s++) begin
      if (s == 1) begin
        mode_i = ~m;
        line_len_i = 11'd3;
      end
      w = 16'h1234 + 16'(s / n) * 16'h4444;
      drive(1'b0, 1'b1, 1'b1, 1'b0, w);
      if ((s % n) == 0) exp = V_LOAD;
      else              exp = {2'b00, 4'b0001 << m, 2'b00};
      exp[0] = (s == nslots - 1);
      chk($sformatf("%s_s%0d", tag, s), obs_v, exp);
      if ((s % n) == 0) chk($sformatf("%s_dat%0d", tag, s), dat_o, w);
      loads  += load_o;
      acks   += word_ack_o;
      shifts += (shift1_o | shift2_o | shift4_o | shift8_o);
      eols   += eol_o;
      adv();
    end
    chk({tag, "_loads"}, loads, exp_loads);
    chk({tag, "_acks"}, acks, exp_loads);
    chk({tag, "_shifts"}, shifts, exp_shifts);
    chk({tag, "_eols"}, eols, 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    chk({tag, "_after_idle"}, obs_v, V_IDLE);
    adv();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    adv();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mode_i = 2'b00;
    line_len_i = 11'd32;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'hA5A5);
    adv();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'hA5A5);
    chk("rst_outs", obs_v, V_IDLE);
    chk("rst_underrun", underrun_o, 0);
    chk("rst_dat", dat_o, 16'hA5A5);
    adv();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("post_rst_idle", obs_v, V_IDLE);
    adv();

    run_full(2'b00, 11'd32, 32, 2, 30, "bpp1");
    run_full(2'b11, 11'd6, 6, 3, 3, "bpp8");

    // 4bpp, 3 starved FETCH cycles; clear coincides with the first set.
    mode_i = 2'b10;
    line_len_i = 11'd12;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    adv();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    chk("ur_s0", obs_v, V_IDLE);
    adv();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("ur_s1", obs_v, V_IDLE);
    chk("ur_set_beats_clr", underrun_o, 1);
    adv();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("ur_s2", obs_v, V_IDLE);
    adv();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    chk("ur_s3_load", obs_v, V_LOAD);
    chk("ur_s3_dat", dat_o, 16'hBEEF);
    adv();
    for (int s = 4; s < 7; s++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      chk($sformatf("ur_s%0d", s), obs_v, V_SH4);
      adv();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h1111);
    chk("ur_s7_load", obs_v, V_LOAD);
    chk("ur_sticky", underrun_o, 1);
    adv();
    for (int s = 8; s < 11; s++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      chk($sformatf("ur_s%0d", s), obs_v, V_SH4);
      if (s == 8) chk("ur_cleared", underrun_o, 0);
      adv();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h2222);
    chk("ur_s11_load_eol", obs_v, V_LOAD | 8'h01);
    adv();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("ur_idle", obs_v, V_IDLE);
    adv();

    // 2bpp, den drops at slot 5; mode/len changed mid-line.
    mode_i = 2'b01;
    line_len_i = 11'd20;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    adv();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0F0F);
    chk("den_s0", obs_v, V_LOAD);
    adv();
    for (int s = 1; s < 5; s++) begin
      if (s == 2) begin
        mode_i = 2'b11;
        line_len_i = 11'd5;
      end
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      chk($sformatf("den_s%0d", s), obs_v, V_SH2);
      adv();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("den_drop", obs_v, V_IDLE);
    adv();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    chk("den_then_idle", obs_v, V_IDLE);
    adv();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    adv();

    // den drop on the line-end slot suppresses eol.
    mode_i = 2'b11;
    line_len_i = 11'd2;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    adv();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h3333);
    chk("eolden_s0", obs_v, V_LOAD);
    adv();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("eolden_s1", obs_v, V_IDLE);
    adv();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    chk("eolden_idle", obs_v, V_IDLE);
    adv();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    adv();

    // 1bpp line with one underrun, then reset at slot 10.
    mode_i = 2'b00;
    line_len_i = 11'd32;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    adv();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("mrst_s0", obs_v, V_IDLE);
    adv();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h4444);
    chk("mrst_s1", obs_v, V_LOAD);
    adv();
    for (int s = 2; s < 10; s++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      chk($sformatf("mrst_s%0d", s), obs_v, V_SH1);
      adv();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    chk("mrst_ur_before", underrun_o, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    chk("mrst_rst_outs", obs_v, V_IDLE);
    chk("mrst_rst_ur", underrun_o, 0);
    adv();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    chk("mrst_idle", obs_v, V_IDLE);
    chk("mrst_ur_after", underrun_o, 0);
    adv();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h5555);
    chk("mrst_restart", obs_v, V_LOAD);
    adv();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    adv();

    run_full(2'b11, 11'd0, 2048, 1024, 1024, "len0");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
